// File: rtl/lookup_pkg.sv
// Shared definitions for the flow-lookup path: tuple/result widths and the
// arbiter FSM state encoding. The lookup engine uses the same widths.
package lookup_pkg;

    localparam int TUPLE_W = 96;
    localparam int PORT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requesting port found searching
// upward (mod NPORT) from last_grant+1.
module rr_arbiter #(
    parameter int NPORT = 4,
    parameter int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    // Scan from the farthest offset down to the nearest so the closest
    // requester after last_grant is the one left standing.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = NPORT; k >= 1; k--) begin
            if (req[IDX_W'((int'(last_grant) + k) % NPORT)]) begin
                grant = IDX_W'((int'(last_grant) + k) % NPORT);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lookup_arbiter.sv
// Shares one flow-lookup engine between NPORT ingress ports. Requests are
// serialised round-robin, issued to the engine one at a time, and each result
// is returned to the issuing port with a one-cycle ack pulse.
// Optional feature: define LOOKUP_TIMEOUT_EN to abort engine waits after
// TIMEOUT cycles (result dropped, err=1). Without it err is tied low.
module lookup_arbiter
    import lookup_pkg::*;
#(
    parameter int NPORT   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NPORT-1:0]         req,
    input  logic [NPORT*TUPLE_W-1:0] tuple,
    output logic [NPORT-1:0]         ack,
    output logic [PORT_W-1:0]        fwd_port,
    output logic                     err,
    output logic                     lu_req,
    output logic [TUPLE_W-1:0]       lu_tuple,
    input  logic                     lu_ack,
    input  logic [PORT_W-1:0]        lu_fwd_port
);

    localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    state_t             state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   arb_grant;
    logic               arb_valid;
    logic [TUPLE_W-1:0] tuple_arr [NPORT];

    // Per-port view of the flattened tuple bus.
    for (genvar i = 0; i < NPORT; i++) begin : g_tuple
        assign tuple_arr[i] = tuple[TUPLE_W*i +: TUPLE_W];
    end

    rr_arbiter #(
        .NPORT (NPORT),
        .IDX_W (IDX_W)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

`ifdef LOOKUP_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    // Transaction FSM: grant in IDLE, one-cycle engine request in ISSUE,
    // collect the result in WAIT, one-cycle ack pulse in RESP. lu_ack is only
    // looked at in WAIT so a stale engine ack cannot complete anything.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NPORT - 1);
            ack        <= '0;
            fwd_port   <= '0;
            lu_req     <= 1'b0;
            lu_tuple   <= '0;
`ifdef LOOKUP_TIMEOUT_EN
            err        <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant    <= arb_grant;
                        lu_tuple <= tuple_arr[arb_grant];
                        lu_req   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    lu_req <= 1'b0;
                    state  <= WAIT;
`ifdef LOOKUP_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (lu_ack) begin
                        fwd_port <= lu_fwd_port;
                        ack      <= NPORT'(1) << grant;
                        state    <= RESP;
`ifdef LOOKUP_TIMEOUT_EN
                        err      <= 1'b0;
`endif
                    end
`ifdef LOOKUP_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        fwd_port <= '0;
                        ack      <= NPORT'(1) << grant;
                        err      <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    ack        <= '0;
                    last_grant <= grant;
                    state      <= IDLE;
`ifdef LOOKUP_TIMEOUT_EN
                    err        <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lookup_arbiter.md
# lookup_arbiter

Round-robin arbiter that shares one flow-lookup engine (96-bit tuple in, 4-bit forward-port mask out, req/ack handshake) between NPORT ingress ports. It sits between the per-port receive pipelines and the single lookup engine. It serialises their requests, drives the engine one request at a time, and returns each result to the port that issued it.

## Interface
Parameters:
- NPORT, 4, number of requesting ports (2..8).
- TIMEOUT, 16, engine-response cycles allowed before abort (used only with the timeout feature).

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  reset; synchronous, active-high.
- req  in  NPORT  per-port lookup request, level.
- tuple  in  NPORT*96  per-port tuple; port i occupies bits [96*i+95:96*i].
- ack  out  NPORT  per-port one-cycle completion pulse.
- fwd_port  out  4  result bus; valid only while any ack bit is high.
- err  out  1  high with ack when the lookup timed out.
- lu_req  out  1  engine request.
- lu_tuple  out  96  engine tuple.
- lu_ack  in  1  engine acknowledge.
- lu_fwd_port  in  4  engine result; sampled when lu_ack=1.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any req is high, grant the first requesting port searching upward (mod NPORT) from last_grant+1.
  - Register grant, copy that port's tuple into lu_tuple, set lu_req=1, go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE
  - lu_req is high for exactly this one cycle.
  - Go to WAIT; lu_req=0 from the next cycle.
- WAIT
  - On lu_ack=1: capture lu_fwd_port into fwd_port, set ack[grant]=1 and err=0, go to RESP.
  - Otherwise stay in WAIT.
- RESP
  - ack[grant] is high for this one cycle.
  - last_grant<=grant; clear ack; go to IDLE.
- Requester rules:
  - Hold req high and tuple stable from assertion until ack is sampled.
  - Deassert req on the clock edge at which ack=1 is sampled.
  - A req still high in the IDLE cycle that follows RESP is treated as a new request.
- lu_ack is ignored outside WAIT.
  - The engine does not clear its ack on reset, so stale lu_ack must never complete a transaction.
- fwd_port holds its last value between transactions.
- Round robin:
  - last_grant resets to NPORT-1, so port 0 has first priority after reset.
  - No port is granted twice while another port is continuously requesting.
- Changes to req or tuple while a port is not granted have no effect.
- Requests arriving during ISSUE, WAIT or RESP wait for the next IDLE.

## Timing
- Reset values: state=IDLE, ack=0, fwd_port=4'b0000, err=0, lu_req=0, lu_tuple=0, last_grant=NPORT-1, timeout counter=0.
- Reset asserted in any state aborts the transaction. No ack is issued for it; the requester re-presents after reset.
- Latency with a 1-cycle engine:
  - req high in cycle 0 (IDLE);
  - lu_req high in cycle 1;
  - lu_ack high in cycle 2;
  - ack high in cycle 3.
- Throughput: one lookup per 4 cycles when back-to-back.
- Engine latency L>=1 cycles after lu_req gives a request-to-ack latency of L+2.

## Configuration
- LOOKUP_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT.
  - If lu_ack is not seen by the TIMEOUT-th WAIT cycle, go to RESP with fwd_port=4'b0000 (drop) and err=1.
  - The counter clears on every WAIT entry.
  - lu_ack arriving in the same cycle as expiry wins: normal result, err=0.
- LOOKUP_TIMEOUT_EN undefined:
  - No counter; WAIT waits indefinitely.
  - err is tied to 0.

## Structure
- Shared package lookup_pkg holds:
  - TUPLE_W=96 and PORT_W=4;
  - the state enum (IDLE, ISSUE, WAIT, RESP).
  The lookup engine uses the same TUPLE_W and PORT_W.
- Sub-module rr_arbiter:
  - combinational;
  - inputs req[NPORT-1:0] and last_grant;
  - outputs grant index plus a valid bit.
  The FSM, data muxing and timeout stay in lookup_arbiter.

## Test plan
- Single port 2 requests with tuple[95:48]=48'h000000_000002 against the engine model → ack[2] in cycle 3, fwd_port=4'b0100, err=0, lu_req high exactly one cycle.
- All four ports request simultaneously and hold → grants in order 0,1,2,3, each ack 4 cycles apart; port 0 re-requests immediately → granted after port 3.
- Broadcast: port 1 requests with DMAC 48'hffffff_ffffff, engine model with PORT_NUM=1 → fwd_port=4'b1101.
- Stale lu_ack=1 held in IDLE after reset with no req → no ack, state stays IDLE; then port 3 requests → exactly one ack[3].
- LOOKUP_TIMEOUT_EN with engine model never acking, TIMEOUT=16 → ack[0] with err=1 and fwd_port=0 sixteen WAIT cycles after entry; the next request completes normally.
- sys_rst pulsed during WAIT → all outputs return to reset values next cycle; no ack for the aborted port; the re-presented request completes with normal 3-cycle latency.
